// File: rtl/dmem_ws.sv
// Data memory with byte/half/word access, sign/zero-extended loads and a
// fixed number of wait states behind a req/ready/busy handshake.
module dmem_ws #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [3:0]  WAIT_W  = 4'(WAIT);

    if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
        $error("dmem_ws: WAIT must be in 0..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        accept, commit;

    logic        we_reg, uns_reg;
    logic [1:0]  size_reg;
    logic [31:0] a_reg, wd_reg;

    logic        cur_we, cur_uns;
    logic [1:0]  cur_size;
    logic [31:0] cur_a, cur_wd;

    logic        legal;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wlane;

    logic        err_reg, ld_ok_reg, ld_uns_reg;
    logic [1:0]  ld_size_reg, ld_lane_reg;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    logic [31:0] mem [DEPTH];
    logic [31:0] ram_q;

    // With WAIT=0 the commit happens on the accept edge, so the live inputs are used.
    assign cur_we   = (state_reg == S_IDLE) ? we   : we_reg;
    assign cur_uns  = (state_reg == S_IDLE) ? uns  : uns_reg;
    assign cur_size = (state_reg == S_IDLE) ? size : size_reg;
    assign cur_a    = (state_reg == S_IDLE) ? a    : a_reg;
    assign cur_wd   = (state_reg == S_IDLE) ? wd   : wd_reg;
    assign idx      = cur_a[AW+1:2];

    always_comb begin
        legal = ({2'b00, cur_a[31:2]} < DEPTH_W);
        case (cur_size)
            2'b00:   legal = legal;
            2'b01:   if (cur_a[0]) legal = 1'b0;
            2'b10:   if (cur_a[1:0] != 2'b00) legal = 1'b0;
            default: legal = 1'b0;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign be[gi] = (cur_size == 2'b10)
                     || (cur_size == 2'b01 && cur_a[1] == LANE[1])
                     || (cur_size == 2'b00 && cur_a[1:0] == LANE);
        assign wlane[8*gi +: 8] = (cur_size == 2'b10) ? cur_wd[8*gi +: 8] :
                                  (cur_size == 2'b01) ? cur_wd[8*(gi%2) +: 8] :
                                                        cur_wd[7:0];
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req) begin
                    accept   = 1'b1;
                    cnt_next = WAIT_W;
                    if (WAIT == 0) begin
                        state_next = S_RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg <= 4'd1) begin
                    state_next = S_RESP;
                    commit     = 1'b1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // RAM port: no reset so it maps onto block RAM; gated so reset aborts the access.
    always_ff @(posedge clk) begin
        if (commit && legal && !reset) begin
            if (cur_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end else begin
                ram_q <= mem[idx];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= 4'd0;
            we_reg      <= 1'b0;
            uns_reg     <= 1'b0;
            size_reg    <= 2'b00;
            a_reg       <= 32'd0;
            wd_reg      <= 32'd0;
            err_reg     <= 1'b0;
            ld_ok_reg   <= 1'b0;
            ld_uns_reg  <= 1'b0;
            ld_size_reg <= 2'b00;
            ld_lane_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg   <= we;
                uns_reg  <= uns;
                size_reg <= size;
                a_reg    <= a;
                wd_reg   <= wd;
            end
            if (commit) begin
                err_reg <= ~legal;
                if (!legal) begin
                    ld_ok_reg <= 1'b0;
                end else if (!cur_we) begin
                    ld_ok_reg   <= 1'b1;
                    ld_uns_reg  <= cur_uns;
                    ld_size_reg <= cur_size;
                    ld_lane_reg <= cur_a[1:0];
                end
            end
        end
    end

    // Extension works off the registered RAM word, so rd holds until the next load.
    assign byte_v = ram_q[{ld_lane_reg, 3'b000} +: 8];
    assign half_v = ld_lane_reg[1] ? ram_q[31:16] : ram_q[15:0];

    always_comb begin
        rd = 32'd0;
        if (ld_ok_reg) begin
            case (ld_size_reg)
                2'b00:   rd = {{24{byte_v[7] & ~ld_uns_reg}}, byte_v};
                2'b01:   rd = {{16{half_v[15] & ~ld_uns_reg}}, half_v};
                default: rd = ram_q;
            endcase
        end
    end

    assign ready = (state_reg == S_RESP);
    assign busy  = (state_reg != S_IDLE);
    assign err   = ready & err_reg;

endmodule

// File: tb/tb_dmem_ws.sv
// Bench for dmem_ws: three builds (WAIT=0/1/15) checked against an array model
// of memory contents, load extension, legality and response latency.
module tb_dmem_ws;
    logic        clk = 1'b0;
    logic        reset;
    logic        we, uns;
    logic [1:0]  size;
    logic [31:0] a, wd;
    logic [2:0]  req, ready, err, busy;
    logic [31:0] rd [3];

    int total = 0;
    int bad   = 0;
    logic [31:0] mdl [3][64];

    always #5 clk = ~clk;

    dmem_ws #(.DEPTH(64), .WAIT(0)) u_w0 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we), .size(size), .uns(uns),
        .a(a), .wd(wd), .rd(rd[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0]));
    dmem_ws #(.DEPTH(64), .WAIT(1)) u_w1 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we), .size(size), .uns(uns),
        .a(a), .wd(wd), .rd(rd[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1]));
    dmem_ws #(.DEPTH(64), .WAIT(15)) u_w15 (
        .clk(clk), .reset(reset), .req(req[2]), .we(we), .size(size), .uns(uns),
        .a(a), .wd(wd), .rd(rd[2]), .ready(ready[2]), .err(err[2]), .busy(busy[2]));

    function automatic int wt(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 15;
    endfunction

    function automatic bit legal_f(input logic [1:0] s, input logic [31:0] addr);
        if (s == 2'b11) return 1'b0;
        if (s == 2'b01 && (addr % 2) != 0) return 1'b0;
        if (s == 2'b10 && (addr % 4) != 0) return 1'b0;
        return (addr >> 2) < 64;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input int d, input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] addr, input logic [31:0] data, input bit hold,
                          output logic [31:0] got);
        logic [31:0] mask, shift, v;
        int nb, cyc;
        bit ok;
        ok    = legal_f(s, addr);
        nb    = (s == 2'b00) ? 8 : (s == 2'b01) ? 16 : 32;
        mask  = (nb == 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
        shift = (nb == 32) ? 32'd0 : 32'(8 * addr[1:0]);
        @(negedge clk);
        we = w; size = s; uns = u; a = addr; wd = data; req[d] = 1'b1;
        @(posedge clk); #1;
        if (!hold) req[d] = 1'b0;
        chk("busy_after_accept", {31'd0, busy[d]}, 32'd1);
        cyc = 0;
        while (ready[d] !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(wt(d)));
        chk("err", {31'd0, err[d]}, {31'd0, !ok});
        got = rd[d];
        if (!w) begin
            v = 32'd0;
            if (ok) begin
                v = (mdl[d][addr[7:2]] >> shift) & mask;
                if (!u && nb < 32 && v[nb-1]) v = v | ~mask;
            end
            chk("load_rd", rd[d], v);
        end else if (ok) begin
            mdl[d][addr[7:2]] = (mdl[d][addr[7:2]] & ~(mask << shift)) | ((data & mask) << shift);
        end
        $display("dut%0d %s size=%0d uns=%0d a=%h wd=%h rd=%h err=%0d lat=%0d hold=%0d",
                 d, w ? "st" : "ld", s, u, addr, data, rd[d], err[d], cyc, hold);
        @(posedge clk); #1;
        chk("idle_after_resp", {29'd0, busy[d], ready[d], err[d]}, 32'd0);
        req[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] got, addr;
        logic [1:0]  s;
        logic        w, u;
        int          wi, off;
        reset = 1'b1; req = 3'b000; we = 1'b0; size = 2'b00; uns = 1'b0; a = 32'd0; wd = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_rd", rd[d], 32'd0);
            chk("reset_flags", {29'd0, ready[d], err[d], busy[d]}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Fill every word so the model knows all RAM contents.
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 64; i++)
                access(d, 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, 1'b0, got);

        // Directed cases on the WAIT=1 build.
        access(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, got);
        access(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, got);
        chk("t1_lw", got, 32'hDEADBEEF);
        access(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, got);
        access(1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 1'b0, got);
        access(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, got);
        chk("t2_lw", got, 32'h1122AA44);
        access(1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, got);
        chk("t2_lb", got, 32'hFFFFFFAA);
        access(1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, got);
        chk("t2_lbu", got, 32'h000000AA);
        access(1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001, 1'b0, got);
        access(1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, got);
        chk("t3_lh", got, 32'hFFFF8001);
        access(1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, got);
        chk("t3_lhu", got, 32'h00008001);
        access(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, got);
        chk("t3_lw_upper", {16'd0, got[31:16]}, 32'h00008001);

        // Illegal accesses: error response, rd cleared, memory untouched.
        access(1, 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1'b0, got);
        chk("t4_lw_misaligned", got, 32'd0);
        access(1, 1'b0, 2'b01, 1'b0, 32'h01, 32'h0, 1'b0, got);
        access(1, 1'b0, 2'b11, 1'b0, 32'h04, 32'h0, 1'b0, got);
        access(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, got);
        access(1, 1'b1, 2'b10, 1'b0, 32'h06, 32'h55555555, 1'b0, got);
        access(1, 1'b1, 2'b11, 1'b0, 32'h08, 32'h66666666, 1'b0, got);
        access(1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h77777777, 1'b0, got);
        access(1, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, got);
        access(1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0, got);
        access(1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0, got);

        // req held high through the whole access must yield exactly one access.
        for (int d = 0; d < 3; d += 2) begin
            access(d, 1'b1, 2'b10, 1'b0, 32'h40, $urandom, 1'b1, got);
            access(d, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, got);
        end

        // Reset in the middle of a store aborts it.
        for (int d = 1; d < 3; d++) begin
            @(negedge clk);
            we = 1'b1; size = 2'b10; uns = 1'b0; a = 32'h30; wd = ~mdl[d][12]; req[d] = 1'b1;
            @(posedge clk); #1;
            req[d] = 1'b0;
            chk("rst_busy_before", {31'd0, busy[d]}, 32'd1);
            if (d == 2) begin
                repeat (5) @(posedge clk);
                #1;
            end
            reset = 1'b1;
            #1;
            chk("rst_mid_rd", rd[d], 32'd0);
            chk("rst_mid_flags", {29'd0, ready[d], err[d], busy[d]}, 32'd0);
            $display("dut%0d reset during store a=00000030", d);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            access(d, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, got);
        end

        // Randomized traffic against the model.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 50; n++) begin
                w   = 1'($urandom_range(0, 1));
                u   = 1'($urandom_range(0, 1));
                s   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                wi  = int'($urandom_range(0, 69));
                off = int'($urandom_range(0, 3));
                if ($urandom_range(0, 3) != 0) begin
                    if (s == 2'b01) off = off & 2;
                    if (s == 2'b10) off = 0;
                end
                addr = 32'(wi * 4 + off);
                if ($urandom_range(0, 15) == 0) addr[31] = 1'b1;
                access(d, w, s, u, addr, $urandom, 1'($urandom_range(0, 1)), got);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
